// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, state
// encoding and latency constants. The pipeline decode logic uses these too.
package muldiv_unit_pkg;

  localparam int DATA_W  = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Counter preload values: the counter runs from latency-1 down to 0.
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

  // The multi-cycle ops (MULT/MULTU/DIV/DIVU) are exactly the encodings
  // with the top bit clear.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Pipeline <-> multiply/divide unit connection. The pipeline (master) issues
// E-stage MD ops; the unit (slave) returns busy, stall request and HI/LO.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              md_use_D;
  logic              busy;
  logic              stall_req;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output start, op, A, B, md_use_D,
    input  busy, stall_req, HI, LO
  );

  modport slave (
    input  start, op, A, B, md_use_D,
    output busy, stall_req, HI, LO
  );

endinterface

// File: rtl/muldiv_unit_divider.sv
// Combinational divider that isolates the signed/unsigned corner cases:
// divide by zero (quotient all ones, remainder = dividend) and the signed
// most-negative / -1 overflow. Division is done on magnitudes so no signed
// hardware divide ever sees the overflowing pair.
module muldiv_unit_divider
  import muldiv_unit_pkg::*;
(
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic              neg_a;
  logic              neg_b;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] safe_b;
  logic [DATA_W-1:0] mag_q;
  logic [DATA_W-1:0] mag_r;

  // Magnitude divide, then restore signs: quotient negative when operand
  // signs differ (truncation toward zero), remainder follows the dividend.
  always_comb begin
    neg_a  = is_signed & dividend[DATA_W-1];
    neg_b  = is_signed & divisor[DATA_W-1];
    mag_a  = neg_a ? -dividend : dividend;
    mag_b  = neg_b ? -divisor  : divisor;
    safe_b = (mag_b == '0) ? ONE : mag_b;
    mag_q  = mag_a / safe_b;
    mag_r  = mag_a % safe_b;
    if (divisor == '0) begin
      quotient  = '1;
      remainder = dividend;
    end else begin
      quotient  = (neg_a ^ neg_b) ? -mag_q : mag_q;
      remainder = neg_a ? -mag_r : mag_r;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit. MULT/MULTU take 5 cycles and
// DIV/DIVU 10 cycles of busy; MTHI/MTLO write immediately. Operands are
// captured at accept and the result is written to HI/LO on the edge where
// busy falls. stall_req holds the front end while an op is in flight and
// the D-stage instruction touches the unit.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  md
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_op_e            op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  md_op_e              op_in;
  logic                busy;
  logic                mul_signed;
  logic                div_signed;
  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;

  assign op_in = md_op_e'(md.op);
  assign busy  = (state_q == ST_BUSY);

  // Multiply on the latched operands: sign- or zero-extend to 64 bits so a
  // single 64-bit product covers both MULT and MULTU.
  always_comb begin
    mul_signed = (op_q == OP_MULT);
    a_ext      = {{DATA_W{mul_signed & a_q[DATA_W-1]}}, a_q};
    b_ext      = {{DATA_W{mul_signed & b_q[DATA_W-1]}}, b_q};
    prod       = a_ext * b_ext;
  end

  assign div_signed = (op_q == OP_DIV);

  muldiv_unit_divider u_div (
    .is_signed (div_signed),
    .dividend  (a_q),
    .divisor   (b_q),
    .quotient  (quo),
    .remainder (rem)
  );

  // Select the completion value for HI/LO from the registered op.
  always_comb begin
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (op_q == OP_DIV || op_q == OP_DIVU) begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // Next-state: accept ops only in IDLE, count down in BUSY, write the
  // result and return to IDLE when the counter expires at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
              state_d = ST_BUSY;
              cnt_d   = MUL_CNT_INIT;
              op_d    = op_in;
              a_d     = md.A;
              b_d     = md.B;
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_BUSY;
              cnt_d   = DIV_CNT_INIT;
              op_d    = op_in;
              a_d     = md.A;
              b_d     = md.B;
            end
            OP_MTHI: hi_d = md.A;
            OP_MTLO: lo_d = md.A;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Architectural state and control; reset wins over any start and drops a
  // pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Latched op and operands; only meaningful while BUSY, so no reset.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  assign md.busy      = busy;
  assign md.HI        = hi_q;
  assign md.LO        = lo_q;
  assign md.stall_req = md.md_use_D & (busy | (md.start & is_long_op(md.op)));

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have reset reset, synchronous, active-high; clock clk.
REQ-002 The port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-003 The port reset SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 The port start SHALL be: input, 1 bit, E-stage instruction is an MD op this cycle.
REQ-005 The port op SHALL be: input, 3 bits; 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
REQ-006 The port A SHALL be: input, 32 bits, forwarded rs value (E stage).
REQ-007 The port B SHALL be: input, 32 bits, forwarded rt value (E stage).
REQ-008 The port md_use_D SHALL be: input, 1 bit, D-stage instruction is MULT/DIV/MTHI/MTLO/MFHI/MFLO.
REQ-009 The port busy SHALL be: output, 1 bit, multi-cycle operation in progress.
REQ-010 The port stall_req SHALL be: output, 1 bit, request to freeze F/D and flush the ID/EX register.
REQ-011 The ports HI and LO SHALL be: output, 32 bits each, architectural HI/LO registers.

Function
REQ-012 Start SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored (no state change).
REQ-013 An accepted MULT/MULTU/DIV/DIVU SHALL assert busy from the next edge, for 5 cycles (MULT/MULTU) or 10 cycles (DIV/DIVU).
REQ-014 Operands SHALL be latched at the accept edge; later changes of A/B SHALL NOT affect the result.
REQ-015 HI/LO SHALL update on the edge where busy falls (the last busy cycle ends); they SHALL hold their old values while busy.
REQ-016 MULT SHALL give {HI,LO} = signed A*B (64-bit).
REQ-017 MULTU SHALL give {HI,LO} = unsigned A*B (64-bit).
REQ-018 DIV SHALL give LO = signed quotient truncated toward zero and HI = remainder with the sign of A.
REQ-019 DIVU SHALL give LO = unsigned quotient and HI = unsigned remainder.
REQ-020 Divide by zero SHALL give LO=32'hFFFFFFFF and HI=A, with the normal 10-cycle latency.
REQ-021 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-022 MTHI/MTLO SHALL write A into HI/LO at the accept edge, with zero latency and no busy.
REQ-023 Reserved op codes SHALL be no-ops.
REQ-024 stall_req SHALL equal md_use_D & (busy | (start & op is MULT/MULTU/DIV/DIVU)), and SHALL be combinational.
REQ-025 A cycle counter SHALL count down from latency-1 to 0; busy SHALL deassert when the counter expires at 0.
REQ-026 A back-to-back start in the cycle after busy falls SHALL be accepted normally.

Reset
REQ-027 On reset=1 at a rising edge, HI, LO, the counter and busy SHALL be cleared to 0, including mid-operation; the pending result SHALL be discarded.
REQ-028 reset SHALL take priority over start.
REQ-029 stall_req SHALL be 0 in the cycle after reset unless start and md_use_D are asserted.

Structure
REQ-030 Op encodings and the latency constants (MUL_LAT=5, DIV_LAT=10) SHALL reside in the shared package/header used by the pipeline decode logic.
REQ-031 An FSM with states IDLE and BUSY SHALL hold a registered op, operands and counter.
REQ-032 The result SHALL be computed with behavioural operators at completion; no sub-module is required.
REQ-033 An optional sub-module md_divider MAY isolate the signed/unsigned division corner cases.

Verification
REQ-034 The bench SHALL cover: MULT A=32'hFFFFFFFE, B=3 -> busy high 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-035 The bench SHALL cover: MULTU with the same operands -> HI=2, LO=32'hFFFFFFFA.
REQ-036 The bench SHALL cover: DIV A=-7, B=2 -> after 10 cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU A=7, B=0 -> LO=32'hFFFFFFFF, HI=7.
REQ-037 The bench SHALL cover: DIV start with md_use_D=1 for the whole operation -> stall_req=1 in the start cycle and all 10 busy cycles, then 0; a second start while busy is ignored.
REQ-038 The bench SHALL cover: MTHI A=32'h12345678 -> HI updates on the next edge, busy stays 0, LO unchanged.
REQ-039 The bench SHALL cover: reset asserted on the 3rd busy cycle of MULT -> next cycle busy=0, HI=LO=0, and no late result write.
